// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: load imem, run core for a budget plus drain, dump dmem; RUN_CYCLE_CNT_EN adds perf_cycles
module cpu_run_ctrl #(
   parameter int IMEM_CNT_W = 9,
   parameter int DMEM_CNT_W = 10,
   parameter int PIPE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start,
   input  logic [IMEM_CNT_W-1:0] load_words,
   input  logic [31:0]           run_cycles,
   input  logic [63:0]           dump_base,
   input  logic [DMEM_CNT_W-1:0] dump_words,
   input  logic                  host_in_valid,
   output logic                  host_in_ready,
   input  logic [31:0]           host_in_data,
   output logic                  host_out_valid,
   input  logic                  host_out_ready,
   output logic [63:0]           host_out_data,
   output logic                  cpu_enable,
   output logic [63:0]           imem_addr,
   output logic                  imem_wen,
   output logic [31:0]           imem_wdata,
   output logic [63:0]           dmem_addr,
   output logic                  dmem_ren,
   input  logic [63:0]           dmem_rdata,
   output logic                  busy,
`ifdef RUN_CYCLE_CNT_EN
   output logic [31:0]           perf_cycles,
`endif
   output logic                  done
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE} state_t;
   state_t                state;
   logic [IMEM_CNT_W-1:0] lw, li;
   logic [DMEM_CNT_W-1:0] dw, di;
   logic [31:0]           rc, cnt;
   logic [63:0]           base, odata;
   state_t                nx_dump, nx_run;
   assign nx_dump        = dw != '0 ? DUMP_RD : DONE;
   assign nx_run         = rc != '0 ? RUN : nx_dump;
   assign host_in_ready  = state == LOAD;
   assign imem_wen       = host_in_ready & host_in_valid;
   assign imem_wdata     = imem_wen ? host_in_data : '0;
   assign imem_addr      = host_in_ready ? 64'(li) << 2 : '0;
   assign cpu_enable     = state == RUN || state == DRAIN;
   assign dmem_ren       = state == DUMP_RD;
   assign dmem_addr      = dmem_ren ? base + (64'(di) << 3) : '0;
   assign host_out_valid = state == DUMP_OUT;
   assign host_out_data  = odata;
   assign busy           = state != IDLE;
   assign done           = state == DONE;
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
         lw    <= '0;
         li    <= '0;
         dw    <= '0;
         di    <= '0;
         rc    <= '0;
         cnt   <= '0;
         base  <= '0;
         odata <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               lw    <= load_words;
               rc    <= run_cycles;
               base  <= dump_base;
               dw    <= dump_words;
               li    <= '0;
               di    <= '0;
               cnt   <= '0;
               state <= load_words != '0 ? LOAD : run_cycles != '0 ? RUN : dump_words != '0 ? DUMP_RD : DONE;
            end
            LOAD: if (host_in_valid) begin
               li <= li + 1'b1;
               if (li == lw - 1'b1) state <= nx_run;
            end
            RUN: begin
               cnt <= cnt == rc - 32'd1 ? '0 : cnt + 32'd1;
               if (cnt == rc - 32'd1) state <= DRAIN;
            end
            DRAIN: begin
               cnt <= cnt + 32'd1;
               if (cnt == 32'(PIPE_DEPTH - 1)) state <= nx_dump;
            end
            DUMP_RD: state <= DUMP_WAIT;
            DUMP_WAIT: begin
               odata <= dmem_rdata;
               state <= DUMP_OUT;
            end
            DUMP_OUT: if (host_out_ready) begin
               di    <= di + 1'b1;
               state <= di + 1'b1 == dw ? DONE : DUMP_RD;
            end
            DONE: state <= IDLE;
         endcase
      end
   end
`ifdef RUN_CYCLE_CNT_EN
   // Cleared on an accepted start only, so the last run's count survives DONE
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) perf_cycles <= '0;
      else if (state == IDLE && start) perf_cycles <= '0;
      else if (cpu_enable) perf_cycles <= perf_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized sequences checked against a transaction-level model of load/run/dump
module tb_cpu_run_ctrl;
   localparam int IW = 9, DW = 10, PD = 4;
   logic          clk = 1'b0, arst_n, start;
   logic [IW-1:0] load_words;
   logic [31:0]   run_cycles;
   logic [63:0]   dump_base;
   logic [DW-1:0] dump_words;
   logic          host_in_valid, host_in_ready, host_out_valid, host_out_ready;
   logic [31:0]   host_in_data, imem_wdata;
   logic [63:0]   host_out_data, imem_addr, dmem_addr, dmem_rdata;
   logic          cpu_enable, imem_wen, dmem_ren, busy, done;
`ifdef RUN_CYCLE_CNT_EN
   logic [31:0]   perf_cycles;
`endif
   int            checks = 0, failures = 0;
   logic [31:0]   prog[$];
   int            stall_n = 0;
   int            r_wen_first, r_wen_last, r_en_first, r_en_n, r_done_k;

   always #5 clk = ~clk;

   cpu_run_ctrl dut (
      .clk(clk), .arst_n(arst_n), .start(start), .load_words(load_words),
      .run_cycles(run_cycles), .dump_base(dump_base), .dump_words(dump_words),
      .host_in_valid(host_in_valid), .host_in_ready(host_in_ready), .host_in_data(host_in_data),
      .host_out_valid(host_out_valid), .host_out_ready(host_out_ready), .host_out_data(host_out_data),
      .cpu_enable(cpu_enable), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
      .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata), .busy(busy),
`ifdef RUN_CYCLE_CNT_EN
      .perf_cycles(perf_cycles),
`endif
      .done(done)
   );

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   // Model: words go to 4*i in order, enable is one contiguous burst of rc+PD (or none),
   // reads hit base+8*i, and beat i carries mem_word(base+8*i)
   task automatic run_seq(input string name, input int lw, input int rc, input logic [63:0] base,
                          input int dw, input int vp, input int rp, input bit noise);
      int pi = 0, ri = 0, oi = 0, en_n = 0, en_first = -1, en_last = -1, k = 0, vcnt = 0, order_err = 0;
      int ex_en;
      bit held = 0, prev_ren = 0, finished = 0;
      logic [63:0] hold_d, prev_addr = '0, exp_d;
      ex_en = rc == 0 ? 0 : rc + PD;
      r_wen_first = -1;
      r_wen_last = -1;
      r_done_k = -1;
      while (prog.size() < lw) prog.push_back($urandom);
      @(negedge clk);
      start = 1'b1;
      load_words = IW'(lw);
      run_cycles = 32'(rc);
      dump_base = base;
      dump_words = DW'(dw);
      host_in_valid = 1'b0;
      host_out_ready = 1'b0;
      @(negedge clk);
      while (!finished && k < 5000) begin
         start = noise && $urandom_range(0, 3) == 0;
         load_words = IW'($urandom);
         run_cycles = $urandom;
         dump_base = {$urandom, $urandom};
         dump_words = DW'($urandom);
         host_in_valid = $urandom_range(0, 99) < vp;
         host_in_data = pi < lw ? prog[pi] : $urandom;
         host_out_ready = vcnt >= stall_n && $urandom_range(0, 99) < rp;
         dmem_rdata = prev_ren ? mem_word(prev_addr) : {$urandom, $urandom};
         #1;
         prev_ren = dmem_ren;
         prev_addr = dmem_addr;
         if (imem_wen) begin
            checks++;
            if (pi >= lw || imem_addr !== 64'(pi) * 4 || imem_wdata !== prog[pi]) begin
               failures++;
               $display("FAIL %s imem_write #%0d: addr=%h data=%h, want addr=%h (of %0d words)",
                        name, pi, imem_addr, imem_wdata, 64'(pi) * 4, lw);
            end
            if (r_wen_first < 0) r_wen_first = k;
            r_wen_last = k;
            pi++;
         end
         if (cpu_enable) begin
            if (en_first < 0) en_first = k;
            en_last = k;
            en_n++;
            if (pi != lw || ri != 0) order_err++;
         end
         if (dmem_ren) begin
            checks++;
            if (ri >= dw || dmem_addr !== base + 64'(ri) * 8) begin
               failures++;
               $display("FAIL %s dmem_read #%0d: addr=%h, want %h (of %0d words)",
                        name, ri, dmem_addr, base + 64'(ri) * 8, dw);
            end
            ri++;
         end
         if (host_out_valid) begin
            vcnt++;
            if (held) begin
               checks++;
               if (host_out_data !== hold_d) begin
                  failures++;
                  $display("FAIL %s out_hold: data=%h, want held %h", name, host_out_data, hold_d);
               end
            end
            if (host_out_ready) begin
               exp_d = mem_word(base + 64'(oi) * 8);
               checks++;
               if (oi >= dw || host_out_data !== exp_d) begin
                  failures++;
                  $display("FAIL %s out_beat #%0d: data=%h, want %h", name, oi, host_out_data, exp_d);
               end
               oi++;
               held = 0;
            end else begin
               held = 1;
               hold_d = host_out_data;
            end
         end else held = 0;
         if (done) begin
            finished = 1;
            r_done_k = k;
         end
         k++;
         @(negedge clk);
      end
      start = 1'b0;
      #1;
      r_en_first = en_first;
      r_en_n = en_n;
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL %s timeout: no done after %0d cycles, want done", name, k);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s after_done: busy=%b done=%b, want 0 0", name, busy, done);
      end
      checks++;
      if (pi != lw || ri != dw || oi != dw) begin
         failures++;
         $display("FAIL %s counts: writes=%0d reads=%0d beats=%0d, want %0d %0d %0d", name, pi, ri, oi, lw, dw, dw);
      end
      checks++;
      if (en_n != ex_en || (en_n > 0 && en_last - en_first + 1 != en_n) || order_err != 0) begin
         failures++;
         $display("FAIL %s enable: cycles=%0d span=%0d misplaced=%0d, want %0d contiguous 0",
                  name, en_n, en_last - en_first + 1, order_err, ex_en);
      end
`ifdef RUN_CYCLE_CNT_EN
      checks++;
      if (perf_cycles !== 32'(ex_en)) begin
         failures++;
         $display("FAIL %s perf_cycles: %0d, want %0d", name, perf_cycles, ex_en);
      end
`endif
      prog.delete();
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      start = 1'b0;
      host_in_valid = 1'b1;
      host_out_ready = 1'b0;
      host_in_data = '1;
      dmem_rdata = '1;
      load_words = '0;
      run_cycles = '0;
      dump_base = '0;
      dump_words = '0;
      #1;
      checks++;
      if ({busy, done, cpu_enable, host_in_ready, imem_wen, dmem_ren, host_out_valid,
           imem_addr, imem_wdata, dmem_addr, host_out_data} !== '0) begin
         failures++;
         $display("FAIL reset_state: busy=%b wen=%b addr=%h wdata=%h, want all outputs 0", busy, imem_wen, imem_addr, imem_wdata);
      end
      repeat (2) @(negedge clk);
      host_in_valid = 1'b0;
      arst_n = 1'b1;
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 5; i++) prog.push_back($urandom);
      @(negedge clk);
      start = 1'b1;
      load_words = 5;
      run_cycles = 3;
      dump_words = 1;
      dump_base = 64'h100;
      @(negedge clk);
      start = 1'b0;
      host_in_valid = 1'b1;
      host_in_data = prog[0];
      @(negedge clk);
      host_in_data = prog[1];
      @(negedge clk);
      host_in_data = prog[2];
      #2 arst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, cpu_enable, host_in_ready, imem_wen, dmem_ren, host_out_valid,
           imem_addr, imem_wdata, dmem_addr, host_out_data} !== '0) begin
         failures++;
         $display("FAIL reset_mid_load: busy=%b ready=%b wen=%b addr=%h, want all outputs 0", busy, host_in_ready, imem_wen, imem_addr);
      end
      @(negedge clk);
      host_in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_beats_start: busy=%b, want 0", busy);
      end
      arst_n = 1'b1;
      prog.delete();
      run_seq("restart_after_reset", 5, 3, 64'h100, 1, 60, 70, 0);
   endtask

   task automatic test_load3();
      prog = '{32'h0050_0093, 32'h0060_0113, 32'h0020_81B3};
      run_seq("load3", 3, $urandom_range(1, 20), 64'h40, 1, 100, 100, 0);
      checks++;
      if (r_wen_first != 0 || r_wen_last != 2 || r_en_first != 3) begin
         failures++;
         $display("FAIL load3_timing: wen cycles %0d..%0d run at %0d, want 0..2 run at 3", r_wen_first, r_wen_last, r_en_first);
      end
   endtask

   task automatic test_run14();
      run_seq("run14", $urandom_range(1, 4), 10, {$urandom, $urandom}, 1, 80, 80, 0);
      checks++;
      if (r_en_n != 14) begin
         failures++;
         $display("FAIL run14: enable cycles=%0d, want 14", r_en_n);
      end
   endtask

   task automatic test_dump_stall();
      stall_n = 5;
      run_seq("dump_stall", 2, 3, 64'h10, 2, 100, 100, 0);
      stall_n = 0;
   endtask

   task automatic test_zero();
      run_seq("all_zero", 0, 0, 64'h0, 0, 100, 100, 0);
      checks++;
      if (r_done_k != 0 || r_en_n != 0) begin
         failures++;
         $display("FAIL all_zero: done at cycle %0d enable=%0d, want 0 and 0", r_done_k, r_en_n);
      end
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 3; i++)
         run_seq("start_while_busy", $urandom_range(1, 6), $urandom_range(1, 12), {$urandom, $urandom},
                 $urandom_range(1, 4), 70, 60, 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         run_seq("random", $urandom_range(0, 10), $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 25),
                 i % 4 == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom},
                 $urandom_range(0, 5), $urandom_range(30, 100), $urandom_range(30, 100), i % 3 == 0);
   endtask

   initial begin
      test_reset();
      test_reset_mid_load();
      test_load3();
      test_run14();
      test_dump_stall();
      test_zero();
      test_start_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
